// File: rtl/mips_exec_ctrl_if.sv
// Avalon-side memory request signals between the execution controller and the bus master.
interface mips_exec_ctrl_if;
  logic        ram_read_en_o;
  logic        ram_write_en_o;
  logic [3:0]  ram_byte_en_o;
  logic        ram_addr_sel_o;
  logic [31:0] ram_readdata_i;

  modport master (
    output ram_read_en_o, ram_write_en_o, ram_byte_en_o, ram_addr_sel_o,
    input  ram_readdata_i
  );

  modport slave (
    input  ram_read_en_o, ram_write_en_o, ram_byte_en_o, ram_addr_sel_o,
    output ram_readdata_i
  );
endinterface

// File: rtl/mips_exec_ctrl.sv
// Multi-cycle MIPS-I sequencer, control decode and execution unit with HI/LO registers.
// state | meaning
// FETCH | read instruction word from PC into IR
// EXEC  | execute IR, advance PC, write regfile / access memory
// HALT  | PC reached 0; frozen until reset
module mips_exec_ctrl (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        halt_i,
  input  logic        stall_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  regimm_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] immediate_i,
  input  logic [25:0] target_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] pc_i,
  mips_exec_ctrl_if.master bus,
  output logic [1:0]  state_o,
  output logic        pc_write_en_o,
  output logic        ir_write_en_o,
  output logic        regfile_write_en_o,
  output logic [1:0]  regfile_addr_3_sel_o,
  output logic [31:0] rd_o,
  output logic [31:0] rt_o,
  output logic [31:0] effective_address_o,
  output logic        b_cond_met_o,
  output logic [31:0] mfhi_o,
  output logic [31:0] mflo_o,
  output logic [1:0]  load_store_byte_offset_o
);
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23,
                         OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                         F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B,
                         F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                         F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [1:0] SEL_RD = 2'd0, SEL_RT = 2'd1, SEL_GPR31 = 2'd2;

  state_e      state, state_nxt;
  logic [31:0] hi, lo, hi_nxt, lo_nxt;
  logic [31:0] imm_sext, imm_zext, pc_plus4, pc_plus8, br_target, divisor;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        rf_we, is_lw, is_sw;
  logic [1:0]  rf_sel;

  assign imm_sext  = {{16{immediate_i[15]}}, immediate_i};
  assign imm_zext  = {16'h0000, immediate_i};
  assign pc_plus4  = pc_i + 32'd4;
  assign pc_plus8  = pc_i + 32'd8;
  assign br_target = pc_plus4 + (imm_sext << 2);
  assign is_lw     = (opcode_i == OP_LW);
  assign is_sw     = (opcode_i == OP_SW);

  assign prod_s  = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
  assign prod_u  = {32'h0, rs_i} * {32'h0, rt_i};
  // Substitute divisor keeps the dividers defined; a zero divisor never commits.
  assign divisor = (rt_i == 32'h0) ? 32'd1 : rt_i;
  assign quot_s  = $signed(rs_i) / $signed(divisor);
  assign rem_s   = $signed(rs_i) % $signed(divisor);
  assign quot_u  = rs_i / divisor;
  assign rem_u   = rs_i % divisor;

  always_comb begin
    rd_o                = '0;
    rt_o                = '0;
    effective_address_o = '0;
    b_cond_met_o        = 1'b0;
    rf_we               = 1'b0;
    rf_sel              = SEL_RD;
    hi_nxt              = hi;
    lo_nxt              = lo;
    case (opcode_i)
      OP_SPECIAL: begin
        rf_we = 1'b1;
        case (funct_i)
          F_SLL:   rd_o = rt_i << shamt_i;
          F_SRL:   rd_o = rt_i >> shamt_i;
          F_SRA:   rd_o = $signed(rt_i) >>> shamt_i;
          F_SLLV:  rd_o = rt_i << rs_i[4:0];
          F_SRLV:  rd_o = rt_i >> rs_i[4:0];
          F_SRAV:  rd_o = $signed(rt_i) >>> rs_i[4:0];
          F_ADDU:  rd_o = rs_i + rt_i;
          F_SUBU:  rd_o = rs_i - rt_i;
          F_AND:   rd_o = rs_i & rt_i;
          F_OR:    rd_o = rs_i | rt_i;
          F_XOR:   rd_o = rs_i ^ rt_i;
          F_NOR:   rd_o = ~(rs_i | rt_i);
          F_SLT:   rd_o = {31'h0, $signed(rs_i) < $signed(rt_i)};
          F_SLTU:  rd_o = {31'h0, rs_i < rt_i};
          F_MFHI:  rd_o = hi;
          F_MFLO:  rd_o = lo;
          F_JALR: begin
            rd_o                = pc_plus8;
            effective_address_o = rs_i;
            b_cond_met_o        = 1'b1;
          end
          F_JR: begin
            rf_we               = 1'b0;
            effective_address_o = rs_i;
            b_cond_met_o        = 1'b1;
          end
          F_MTHI:  begin rf_we = 1'b0; hi_nxt = rs_i; end
          F_MTLO:  begin rf_we = 1'b0; lo_nxt = rs_i; end
          F_MULT:  begin rf_we = 1'b0; {hi_nxt, lo_nxt} = prod_s; end
          F_MULTU: begin rf_we = 1'b0; {hi_nxt, lo_nxt} = prod_u; end
          F_DIV: begin
            rf_we = 1'b0;
            if (rt_i != 32'h0) begin lo_nxt = quot_s; hi_nxt = rem_s; end
          end
          F_DIVU: begin
            rf_we = 1'b0;
            if (rt_i != 32'h0) begin lo_nxt = quot_u; hi_nxt = rem_u; end
          end
          default: rf_we = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (regimm_i == 5'd0) begin
          effective_address_o = br_target;
          b_cond_met_o        = rs_i[31];
        end else if (regimm_i == 5'd1) begin
          effective_address_o = br_target;
          b_cond_met_o        = ~rs_i[31];
        end
      end
      OP_J, OP_JAL: begin
        effective_address_o = {pc_plus4[31:28], target_i, 2'b00};
        b_cond_met_o        = 1'b1;
        if (opcode_i == OP_JAL) begin
          rd_o   = pc_plus8;
          rf_we  = 1'b1;
          rf_sel = SEL_GPR31;
        end
      end
      OP_BEQ:  begin effective_address_o = br_target; b_cond_met_o = (rs_i == rt_i); end
      OP_BNE:  begin effective_address_o = br_target; b_cond_met_o = (rs_i != rt_i); end
      OP_BLEZ: begin effective_address_o = br_target; b_cond_met_o = ($signed(rs_i) <= 0); end
      OP_BGTZ: begin effective_address_o = br_target; b_cond_met_o = ($signed(rs_i) > 0); end
      OP_ADDIU: begin rt_o = rs_i + imm_sext; rf_we = 1'b1; rf_sel = SEL_RT; end
      OP_SLTI:  begin rt_o = {31'h0, $signed(rs_i) < $signed(imm_sext)}; rf_we = 1'b1; rf_sel = SEL_RT; end
      OP_SLTIU: begin rt_o = {31'h0, rs_i < imm_sext}; rf_we = 1'b1; rf_sel = SEL_RT; end
      OP_ANDI:  begin rt_o = rs_i & imm_zext; rf_we = 1'b1; rf_sel = SEL_RT; end
      OP_ORI:   begin rt_o = rs_i | imm_zext; rf_we = 1'b1; rf_sel = SEL_RT; end
      OP_XORI:  begin rt_o = rs_i ^ imm_zext; rf_we = 1'b1; rf_sel = SEL_RT; end
      OP_LUI:   begin rt_o = {immediate_i, 16'h0000}; rf_we = 1'b1; rf_sel = SEL_RT; end
      OP_LW: begin
        rt_o                = bus.ram_readdata_i;
        effective_address_o = rs_i + imm_sext;
        rf_we               = 1'b1;
        rf_sel              = SEL_RT;
      end
      OP_SW: effective_address_o = rs_i + imm_sext;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state <= FETCH;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      if (state == EXEC && !stall_i) begin
        hi <= hi_nxt;
        lo <= lo_nxt;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    pc_write_en_o      = 1'b0;
    ir_write_en_o      = 1'b0;
    regfile_write_en_o = 1'b0;
    bus.ram_read_en_o  = 1'b0;
    bus.ram_write_en_o = 1'b0;
    bus.ram_byte_en_o  = 4'b0000;
    bus.ram_addr_sel_o = 1'b0;
    case (state)
      FETCH: begin
        bus.ram_read_en_o = 1'b1;
        bus.ram_byte_en_o = 4'b1111;
        ir_write_en_o     = 1'b1;
        if (halt_i)        state_nxt = HALT;
        else if (!stall_i) state_nxt = EXEC;
      end
      EXEC: begin
        pc_write_en_o      = 1'b1;
        regfile_write_en_o = rf_we;
        if (is_lw || is_sw) begin
          bus.ram_addr_sel_o = 1'b1;
          bus.ram_byte_en_o  = 4'b1111;
          bus.ram_read_en_o  = is_lw;
          bus.ram_write_en_o = is_sw;
        end
        if (!stall_i) state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  assign state_o                  = state;
  assign regfile_addr_3_sel_o     = rf_sel;
  assign mfhi_o                   = hi;
  assign mflo_o                   = lo;
  assign load_store_byte_offset_o = effective_address_o[1:0];
endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl: sequencing, ALU, HI/LO, branches, loads/stores and halt.
module tb_mips_exec_ctrl;
  logic        clk = 1'b0;
  logic        reset_i, halt_i, stall_i;
  logic [5:0]  opcode_i, funct_i;
  logic [4:0]  regimm_i, shamt_i;
  logic [15:0] immediate_i;
  logic [25:0] target_i;
  logic [31:0] rs_i, rt_i, pc_i;
  logic [1:0]  state_o, regfile_addr_3_sel_o, load_store_byte_offset_o;
  logic        pc_write_en_o, ir_write_en_o, regfile_write_en_o, b_cond_met_o;
  logic [31:0] rd_o, rt_o, effective_address_o, mfhi_o, mflo_o;
  int          tests = 0;
  int          fails = 0;

  mips_exec_ctrl_if bus ();

  mips_exec_ctrl dut (
    .clk(clk), .reset_i(reset_i), .halt_i(halt_i), .stall_i(stall_i),
    .opcode_i(opcode_i), .funct_i(funct_i), .regimm_i(regimm_i), .shamt_i(shamt_i),
    .immediate_i(immediate_i), .target_i(target_i), .rs_i(rs_i), .rt_i(rt_i), .pc_i(pc_i),
    .bus(bus.master), .state_o(state_o), .pc_write_en_o(pc_write_en_o),
    .ir_write_en_o(ir_write_en_o), .regfile_write_en_o(regfile_write_en_o),
    .regfile_addr_3_sel_o(regfile_addr_3_sel_o), .rd_o(rd_o), .rt_o(rt_o),
    .effective_address_o(effective_address_o), .b_cond_met_o(b_cond_met_o),
    .mfhi_o(mfhi_o), .mflo_o(mflo_o), .load_store_byte_offset_o(load_store_byte_offset_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [15:0] imm);
    opcode_i = op; funct_i = fn; rs_i = rs; rt_i = rt; immediate_i = imm;
  endtask

  function automatic logic [31:0] enables();
    return {23'h0, pc_write_en_o, ir_write_en_o, regfile_write_en_o, bus.ram_read_en_o,
            bus.ram_write_en_o, bus.ram_addr_sel_o, bus.ram_byte_en_o[3:2], bus.ram_byte_en_o[1:0]};
  endfunction

  initial begin
    reset_i = 1'b0; halt_i = 1'b0; stall_i = 1'b0;
    opcode_i = '0; funct_i = '0; regimm_i = '0; shamt_i = '0;
    immediate_i = '0; target_i = '0; rs_i = '0; rt_i = '0; pc_i = '0;
    bus.ram_readdata_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", state_o, 0);
    chk("reset_hi", mfhi_o, 0);
    chk("reset_lo", mflo_o, 0);
    reset_i = 1'b1;
    #1;
    // enable word: pc,ir,rf,rd,wr,asel,be[3:0]
    chk("fetch_enables", enables(), 32'b0_1_0_1_0_0_1111);
    step();
    chk("exec_state", state_o, 1);
    chk("exec_pc_we", pc_write_en_o, 1);

    reset_i = 1'b0;
    #1;
    chk("async_reset_state", state_o, 0);
    reset_i = 1'b1;
    step();
    chk("post_reset_exec", state_o, 1);
    step();
    chk("post_reset_fetch", state_o, 0);
    chk("post_reset_hi", mfhi_o, 0);

    set_instr(6'h00, 6'h21, 32'hFFFFFFFF, 32'h1, 16'h0);
    step();
    chk("addu_rd", rd_o, 32'h0);
    chk("addu_we", regfile_write_en_o, 1);
    chk("addu_sel", regfile_addr_3_sel_o, 0);
    step();

    set_instr(6'h00, 6'h03, 32'h0, 32'h80000000, 16'h0);
    shamt_i = 5'd4;
    step();
    chk("sra_rd", rd_o, 32'hF8000000);
    funct_i = 6'h2B; rs_i = 32'h1; rt_i = 32'hFFFFFFFF;
    #1;
    chk("sltu_rd", rd_o, 32'h1);
    funct_i = 6'h2A;
    #1;
    chk("slt_rd", rd_o, 32'h0);
    step();

    set_instr(6'h0A, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h0000);
    step();
    chk("slti_rt", rt_o, 32'h1);
    chk("slti_sel", regfile_addr_3_sel_o, 1);
    opcode_i = 6'h0C; immediate_i = 16'h8000;
    #1;
    chk("andi_zext", rt_o, 32'h00008000);
    opcode_i = 6'h0F; immediate_i = 16'h1234;
    #1;
    chk("lui_rt", rt_o, 32'h12340000);
    step();

    set_instr(6'h00, 6'h18, 32'hFFFFFFFE, 32'h3, 16'h0);
    step();
    chk("mult_no_we", regfile_write_en_o, 0);
    step();
    chk("mult_hi", mfhi_o, 32'hFFFFFFFF);
    chk("mult_lo", mflo_o, 32'hFFFFFFFA);

    set_instr(6'h00, 6'h1A, 32'h7, 32'hFFFFFFFE, 16'h0);
    step(); step();
    chk("div_lo", mflo_o, 32'hFFFFFFFD);
    chk("div_hi", mfhi_o, 32'h1);

    set_instr(6'h00, 6'h1B, 32'h5, 32'h0, 16'h0);
    step(); step();
    chk("divu0_lo", mflo_o, 32'hFFFFFFFD);
    chk("divu0_hi", mfhi_o, 32'h1);

    set_instr(6'h00, 6'h11, 32'hAAAA5555, 32'h0, 16'h0);
    step(); step();
    chk("mthi_hi", mfhi_o, 32'hAAAA5555);
    set_instr(6'h00, 6'h10, 32'h0, 32'h0, 16'h0);
    step();
    chk("mfhi_rd", rd_o, 32'hAAAA5555);
    step();

    // MTLO held off by a stall in EXEC, then committed once it clears
    set_instr(6'h00, 6'h13, 32'h12345678, 32'h0, 16'h0);
    step();
    stall_i = 1'b1;
    step();
    chk("stall_state", state_o, 1);
    chk("stall_lo", mflo_o, 32'hFFFFFFFD);
    stall_i = 1'b0;
    step();
    chk("mtlo_state", state_o, 0);
    chk("mtlo_lo", mflo_o, 32'h12345678);

    pc_i = 32'h100;
    set_instr(6'h05, 6'h00, 32'h1, 32'h2, 16'hFFFF);
    step();
    chk("bne_taken", b_cond_met_o, 1);
    chk("bne_ea", effective_address_o, 32'h100);
    chk("bne_no_we", regfile_write_en_o, 0);
    rt_i = 32'h1;
    #1;
    chk("bne_equal", b_cond_met_o, 0);
    opcode_i = 6'h06; rs_i = 32'h0;
    #1;
    chk("blez_zero", b_cond_met_o, 1);
    opcode_i = 6'h07;
    #1;
    chk("bgtz_zero", b_cond_met_o, 0);
    opcode_i = 6'h01; regimm_i = 5'd0; rs_i = 32'h80000000;
    #1;
    chk("bltz_neg", b_cond_met_o, 1);
    regimm_i = 5'd1;
    #1;
    chk("bgez_neg", b_cond_met_o, 0);
    step();

    pc_i = 32'h3FFFFFFC; target_i = 26'h0000010;
    set_instr(6'h02, 6'h00, 32'h0, 32'h0, 16'h0);
    step();
    chk("j_ea", effective_address_o, 32'h40000040);
    chk("j_taken", b_cond_met_o, 1);
    step();

    pc_i = 32'h100;
    set_instr(6'h03, 6'h00, 32'h0, 32'h0, 16'h0);
    step();
    chk("jal_rd", rd_o, 32'h108);
    chk("jal_sel", regfile_addr_3_sel_o, 2);
    chk("jal_we", regfile_write_en_o, 1);
    opcode_i = 6'h00; funct_i = 6'h09; rs_i = 32'h2000;
    #1;
    chk("jalr_ea", effective_address_o, 32'h2000);
    chk("jalr_rd", rd_o, 32'h108);
    chk("jalr_sel", regfile_addr_3_sel_o, 0);
    funct_i = 6'h08;
    #1;
    chk("jr_no_we", regfile_write_en_o, 0);
    step();

    set_instr(6'h23, 6'h00, 32'h1000, 32'h0, 16'h0004);
    bus.ram_readdata_i = 32'hDEADBEEF;
    step();
    chk("lw_enables", enables(), 32'b1_0_1_1_0_1_1111);
    chk("lw_ea", effective_address_o, 32'h1004);
    chk("lw_sel", regfile_addr_3_sel_o, 1);
    chk("lw_rt", rt_o, 32'hDEADBEEF);
    step();

    set_instr(6'h2B, 6'h00, 32'h1000, 32'h0, 16'hFFFE);
    step();
    chk("sw_enables", enables(), 32'b1_0_0_0_1_1_1111);
    chk("sw_ea", effective_address_o, 32'h0FFE);
    chk("sw_offset", load_store_byte_offset_o, 2);
    step();

    set_instr(6'h3F, 6'h00, 32'h0, 32'h0, 16'h0);
    step();
    chk("unknown_enables", enables(), 32'b1_0_0_0_0_0_0000);
    step();

    // halt wins over a simultaneous stall
    halt_i = 1'b1; stall_i = 1'b1;
    step();
    chk("halt_state", state_o, 2);
    chk("halt_enables", enables(), 32'h0);
    halt_i = 1'b0; stall_i = 1'b0;
    repeat (3) step();
    chk("halt_sticky", state_o, 2);
    reset_i = 1'b0;
    #1;
    chk("halt_reset", state_o, 0);
    reset_i = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
